// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: opcodes, FSM states, iterator mode and the
// single-cycle ALU function (operands zero-extended to MAXW bits).
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SLT   = 4'd3,
    OP_ADDU  = 4'd4,
    OP_SLL   = 4'd5,
    OP_SUB   = 4'd6,
    OP_SLTU  = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MULTU = 4'd10,
    OP_DIVU  = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_t;

  localparam int unsigned MAXW = 64;
  localparam logic [MAXW-1:0] ONE_W  = {{(MAXW-1){1'b0}}, 1'b1};
  localparam logic [MAXW-1:0] ZERO_W = {MAXW{1'b0}};

  typedef struct packed {
    logic [MAXW-1:0] r;
    logic            cout;
    logic            ovf;
  } sc_res_t;

  // The live width is a run-time argument so one function serves any WIDTH <= MAXW.
  function automatic sc_res_t alu_single(input logic [3:0]      op,
                                         input logic [MAXW-1:0] a,
                                         input logic [MAXW-1:0] b,
                                         input int unsigned     shamt,
                                         input int unsigned     width);
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] msb;
    logic [MAXW-1:0] sext;
    logic [MAXW-1:0] sra;
    logic [MAXW:0]   wide;
    logic [MAXW:0]   carry;
    logic            sa;
    logic            sb;
    logic            big;
    sc_res_t         o;
    mask   = (width >= MAXW) ? {MAXW{1'b1}} : ((ONE_W << width) - ONE_W);
    msb    = ONE_W << (width - 32'd1);
    sa     = |(a & msb);
    sb     = |(b & msb);
    big    = (shamt >= width);
    sext   = sa ? (a | ~mask) : a;
    sra    = $signed(sext) >>> shamt;
    wide   = {1'b0, a} + {1'b0, b};
    carry  = wide >> width;
    o.r    = ZERO_W;
    o.cout = 1'b0;
    o.ovf  = 1'b0;
    case (op)
      OP_AND:  o.r = a & b;
      OP_OR:   o.r = a | b;
      OP_ADD: begin
        o.r    = wide[MAXW-1:0] & mask;
        o.cout = carry[0];
        o.ovf  = (sa == sb) && ((|(o.r & msb)) != sa);
      end
      OP_ADDU: begin
        o.r    = wide[MAXW-1:0] & mask;
        o.cout = carry[0];
        o.ovf  = carry[0];
      end
      OP_SUB: begin
        o.r    = (a - b) & mask;
        o.cout = (a < b);
        o.ovf  = (sa != sb) && ((|(o.r & msb)) != sa);
      end
      OP_SLT:  o.r = (sa != sb) ? (sa ? ONE_W : ZERO_W) : ((a < b) ? ONE_W : ZERO_W);
      OP_SLTU: o.r = (a < b) ? ONE_W : ZERO_W;
      OP_SLL:  o.r = big ? ZERO_W : ((a << shamt) & mask);
      OP_SRL:  o.r = big ? ZERO_W : (a >> shamt);
      OP_SRA:  o.r = big ? (sa ? mask : ZERO_W) : (sra & mask);
      default: o.r = ZERO_W;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Shared WIDTH-bit iterative datapath: shift-add multiply or restoring divide.
// res_lo/res_hi expose the next step's value so the final step can be captured directly.
module muldiv_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_mode_t         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0]    cnt_r;
  logic             run_r;
  md_mode_t         mode_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   diff_s;

  assign done = run_r && (cnt_r == CNT_LAST);

  // One iteration step; a set top bit of diff_s means the trial subtract went negative.
  always_comb begin
    sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    shl_s  = {hi_r, lo_r[WIDTH-1]};
    diff_s = shl_s - {1'b0, b_r};
    res_lo = lo_r;
    res_hi = hi_r;
    if (mode_r == MODE_DIV) begin
      if (diff_s[WIDTH]) begin
        res_hi = shl_s[WIDTH-1:0];
        res_lo = {lo_r[WIDTH-2:0], 1'b0};
      end else begin
        res_hi = diff_s[WIDTH-1:0];
        res_lo = {lo_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      res_hi = sum_s[WIDTH:1];
      res_lo = {sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Operand load on start, then WIDTH steps counted 0..WIDTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      run_r  <= 1'b0;
      mode_r <= MODE_MUL;
      lo_r   <= {WIDTH{1'b0}};
      hi_r   <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
    end else if (start) begin
      cnt_r  <= {CW{1'b0}};
      run_r  <= 1'b1;
      mode_r <= mode;
      lo_r   <= a;
      hi_r   <= {WIDTH{1'b0}};
      b_r    <= b;
    end else if (run_r) begin
      lo_r <= res_lo;
      hi_r <= res_hi;
      if (cnt_r == CNT_LAST) begin
        run_r <= 1'b0;
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: single-cycle ops finish one cycle after acceptance,
// MULTU/DIVU iterate WIDTH cycles in muldiv_iter; results held until consumed.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] hi,
  output logic             cout,
  output logic             ovf,
  output logic             ze,
  output logic             busy
);

  alu_state_t       state_r;
  alu_state_t       state_nxt_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             is_div_s;
  logic             b_zero_s;
  logic             start_s;
  md_mode_t         mode_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_lo_s;
  logic [WIDTH-1:0] iter_hi_s;
  logic             iter_ze_s;
  sc_res_t          sc_s;
  logic [WIDTH-1:0] sc_r_s;
  logic [WIDTH-1:0] sc_hi_s;
  logic             sc_cout_s;
  logic             sc_ovf_s;
  logic             sc_ze_s;
  logic             unused_s;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] hi_r;
  logic             cout_r;
  logic             ovf_r;
  logic             ze_r;
  logic             out_valid_r;
  logic             busy_r;

  assign in_ready  = (state_r == IDLE) && !rst;
  assign accept_s  = in_valid && in_ready;
  assign is_mul_s  = (op == OP_MULTU);
  assign is_div_s  = (op == OP_DIVU);
  assign b_zero_s  = (b == {WIDTH{1'b0}});
  assign start_s   = accept_s && (is_mul_s || (is_div_s && !b_zero_s));
  assign mode_s    = is_mul_s ? MODE_MUL : MODE_DIV;
  assign iter_ze_s = (state_r == MUL) ? ({iter_hi_s, iter_lo_s} == {(2*WIDTH){1'b0}})
                                      : (iter_lo_s == {WIDTH{1'b0}});
  assign unused_s  = ^sc_s.r;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start_s),
    .mode   (mode_s),
    .a      (a),
    .b      (b),
    .done   (iter_done_s),
    .res_lo (iter_lo_s),
    .res_hi (iter_hi_s)
  );

  // Result of a request that completes straight from IDLE (incl. divide by zero).
  always_comb begin
    sc_s      = alu_single(op, MAXW'(a), MAXW'(b), 32'(shamt), 32'(WIDTH));
    sc_r_s    = sc_s.r[WIDTH-1:0];
    sc_hi_s   = {WIDTH{1'b0}};
    sc_cout_s = sc_s.cout;
    sc_ovf_s  = sc_s.ovf;
    sc_ze_s   = 1'b0;
    case (op)
      OP_DIVU: begin
        sc_r_s    = {WIDTH{1'b1}};
        sc_hi_s   = a;
        sc_cout_s = 1'b0;
        sc_ovf_s  = 1'b1;
      end
      4'd12, 4'd13, 4'd14, 4'd15: sc_ze_s = 1'b0;
      default: sc_ze_s = (sc_r_s == {WIDTH{1'b0}});
    endcase
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_nxt_s = MUL;
          end else if (is_div_s && !b_zero_s) begin
            state_nxt_s = DIV;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (iter_done_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output registers: loaded on single-cycle accept or the last iteration, else held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r         <= {WIDTH{1'b0}};
      hi_r        <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      ze_r        <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s == MUL) || (state_nxt_s == DIV);
      if (accept_s && !start_s) begin
        r_r    <= sc_r_s;
        hi_r   <= sc_hi_s;
        cout_r <= sc_cout_s;
        ovf_r  <= sc_ovf_s;
        ze_r   <= sc_ze_s;
      end else if (iter_done_s && ((state_r == MUL) || (state_r == DIV))) begin
        r_r    <= iter_lo_s;
        hi_r   <= iter_hi_s;
        cout_r <= 1'b0;
        ovf_r  <= 1'b0;
        ze_r   <= iter_ze_s;
      end
    end
  end

  assign R         = r_r;
  assign hi        = hi_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign ze        = ze_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=32 with hand-computed expectations.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [4:0]    shamt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  r;
  logic [W-1:0]  hi;
  logic          cout;
  logic          ovf;
  logic          ze;
  logic          busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t tbl [15];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (r),
    .hi        (hi),
    .cout      (cout),
    .ovf       (ovf),
    .ze        (ze),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble the inputs.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s);
    op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15));
    a = $urandom();
    b = $urandom();
    shamt = 5'($urandom_range(0, 31));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".ov_clr"}, 64'(out_valid), 64'd0);
  endtask

  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!out_valid && n < 100) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n;
  int nb;

  initial begin
    tbl[0]  = '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0,  32'h00F0_1234, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{OP_OR,   32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{OP_ADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{OP_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{OP_SUB,  32'h0000_0003, 32'h0000_0005, 5'd0,  32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{OP_SLL,  32'h0000_0001, 32'h0000_0000, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{OP_SRL,  32'h8000_0000, 32'h0000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{OP_SRA,  32'h8000_0001, 32'h0000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'd12,   32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{4'd15,   32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; a = '0; b = '0; shamt = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.ov", 64'(out_valid), 64'd0);
    check("rst.R", 64'(r), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    check("idle.in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 15; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh);
      check($sformatf("v%0d.ov", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d.R", i), 64'(r), 64'(tbl[i].r));
      check($sformatf("v%0d.hi", i), 64'(hi), 64'd0);
      check($sformatf("v%0d.cout", i), 64'(cout), 64'(tbl[i].c));
      check($sformatf("v%0d.ovf", i), 64'(ovf), 64'(tbl[i].v));
      check($sformatf("v%0d.ze", i), 64'(ze), 64'(tbl[i].z));
      check($sformatf("v%0d.busy", i), 64'(busy), 64'd0);
      consume($sformatf("v%0d", i));
    end

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    check("mul.in_ready", 64'(in_ready), 64'd0);
    wait_done(n, nb);
    check("mul.latency", 64'(n), 64'd32);
    check("mul.busy_cycles", 64'(nb), 64'd32);
    check("mul.R", 64'(r), 64'h0000_0001);
    check("mul.hi", 64'(hi), 64'hFFFF_FFFE);
    check("mul.ze", 64'(ze), 64'd0);
    check("mul.busy_end", 64'(busy), 64'd0);
    consume("mul");

    issue(OP_DIVU, 32'd100, 32'd7, 5'd0);
    wait_done(n, nb);
    check("div.latency", 64'(n), 64'd32);
    check("div.busy_cycles", 64'(nb), 64'd32);
    check("div.R", 64'(r), 64'd14);
    check("div.hi", 64'(hi), 64'd2);
    check("div.ovf", 64'(ovf), 64'd0);
    consume("div");

    issue(OP_SRA, 32'h8000_0000, 32'h0000_0000, 5'd4);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("sra.hold%0d.ov", k), 64'(out_valid), 64'd1);
      check($sformatf("sra.hold%0d.R", k), 64'(r), 64'hF800_0000);
      check($sformatf("sra.hold%0d.in_ready", k), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    consume("sra");

    issue(OP_DIVU, 32'h0000_1234, 32'h0000_0000, 5'd0);
    check("div0.ov", 64'(out_valid), 64'd1);
    check("div0.R", 64'(r), 64'hFFFF_FFFF);
    check("div0.hi", 64'(hi), 64'h0000_1234);
    check("div0.ovf", 64'(ovf), 64'd1);
    check("div0.cout", 64'(cout), 64'd0);
    check("div0.busy", 64'(busy), 64'd0);
    consume("div0");

    issue(OP_MULTU, 32'h0000_0003, 32'h0000_0005, 5'd0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.R", 64'(r), 64'd0);
    check("midrst.hi", 64'(hi), 64'd0);
    check("midrst.ovf", 64'(ovf), 64'd0);
    check("midrst.ov", 64'(out_valid), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst.in_ready", 64'(in_ready), 64'd1);
    check("postrst.busy", 64'(busy), 64'd0);
    issue(OP_SLTU, 32'd1, 32'd2, 5'd0);
    check("sltu.ov", 64'(out_valid), 64'd1);
    check("sltu.R", 64'(r), 64'd1);
    check("sltu.hi", 64'(hi), 64'd0);
    consume("sltu");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
